// File: rtl/inst_decode_stage_pkg.sv
// Shared types and constants for the instruction decode stage:
// instruction type encoding, decoded-field payload and raw field positions.
package inst_decode_stage_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned TYPE_W   = 2;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 16;

  // Bit positions of the raw instruction fields
  localparam int unsigned TYPE_LSB = 0;
  localparam int unsigned OPC_LSB  = 2;
  localparam int unsigned FLD0_LSB = 6;
  localparam int unsigned FLD1_LSB = 11;
  localparam int unsigned FLD2_LSB = 16;
  localparam int unsigned IMM_LSB  = 16;

  typedef enum logic [TYPE_W-1:0] {
    INST_ILLEGAL = 2'b00,
    INST_S       = 2'b01,
    INST_I       = 2'b10,
    INST_B       = 2'b11
  } inst_type_e;

  // Decoded fields except the immediate, whose width follows XLEN
  typedef struct packed {
    inst_type_e       typ;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] cond;
    logic             illegal;
  } dec_fields_t;

endpackage

// File: rtl/inst_decode_stage_field_decode.sv
// inst_field_decode: combinational decode of one raw instruction.
// Ports:
//   inst      in   raw 32-bit instruction
//   fields_c  out  decoded type/opcode/register/cond fields, illegal flag
//   imm_c     out  XLEN-bit extended immediate (zero for S and illegal)
module inst_field_decode
  import inst_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SIGN_EXT = 1
) (
  input  logic [INST_W-1:0] inst,
  output dec_fields_t       fields_c,
  output logic [XLEN-1:0]   imm_c
);

  localparam logic [XLEN-1:0] UPPER_MASK = ~XLEN'({IMM_W{1'b1}});

  logic [XLEN-1:0] imm_ext;
  logic [REG_W-1:0] fld0;
  logic [REG_W-1:0] fld1;
  logic [REG_W-1:0] fld2;
  logic [OPC_W-1:0] opc;

  assign fld0 = inst[FLD0_LSB +: REG_W];
  assign fld1 = inst[FLD1_LSB +: REG_W];
  assign fld2 = inst[FLD2_LSB +: REG_W];
  assign opc  = inst[OPC_LSB +: OPC_W];

  // Immediate extension: fill the upper bits with inst[31] or zeros
  always_comb begin
    imm_ext = XLEN'(inst[IMM_LSB +: IMM_W]);
    if ((SIGN_EXT != 0) && inst[INST_W-1]) begin
      imm_ext = imm_ext | UPPER_MASK;
    end
  end

  always_comb begin
    fields_c = '0;
    imm_c    = '0;
    case (inst_type_e'(inst[TYPE_LSB +: TYPE_W]))
      INST_S: begin
        fields_c.typ    = INST_S;
        fields_c.opcode = opc;
        fields_c.src1   = fld0;
        fields_c.src2   = fld1;
        fields_c.dest   = fld2;
      end
      INST_I: begin
        fields_c.typ    = INST_I;
        fields_c.opcode = opc;
        fields_c.src1   = fld0;
        fields_c.dest   = fld1;
        imm_c           = imm_ext;
      end
      INST_B: begin
        // B reads and writes the same register slot
        fields_c.typ    = INST_B;
        fields_c.opcode = opc;
        fields_c.src2   = fld0;
        fields_c.dest   = fld0;
        fields_c.cond   = fld1;
        imm_c           = imm_ext;
      end
      default: begin
        fields_c.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// inst_decode_stage: decodes incoming instructions and buffers the decoded
// fields in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake, inst is the raw instruction
//   flush               drops all buffered entries and any same-cycle input
//   out_valid/out_ready downstream handshake on the head entry
//   out_type..imm       decoded head-entry fields (zero when out_valid=0)
//   out_illegal         head entry had type 00
module inst_decode_stage
  import inst_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned SIGN_EXT = 1,
  parameter int unsigned DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [INST_W-1:0] inst,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TYPE_W-1:0] out_type,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [REG_W-1:0]  src1,
  output logic [REG_W-1:0]  src2,
  output logic [REG_W-1:0]  dest,
  output logic [REG_W-1:0]  cond,
  output logic [XLEN-1:0]   imm,
  output logic              out_illegal
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  dec_fields_t     in_fields_c;
  logic [XLEN-1:0] in_imm_c;

  dec_fields_t     fld_q [DEPTH];
  dec_fields_t     fld_d [DEPTH];
  logic [XLEN-1:0] imm_q [DEPTH];
  logic [XLEN-1:0] imm_d [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_c;
  logic pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  inst_field_decode #(
    .XLEN     (XLEN),
    .SIGN_EXT (SIGN_EXT)
  ) u_decode (
    .inst     (inst),
    .fields_c (in_fields_c),
    .imm_c    (in_imm_c)
  );

  // A full buffer still accepts when the head leaves in the same cycle
  assign in_ready  = !rst && ((count_q < CNT_W'(DEPTH)) || out_ready);
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  // Next-state for pointers, count and storage; flush wins over push/pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    fld_d    = fld_q;
    imm_d    = imm_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        fld_d[wr_ptr_q] = in_fields_c;
        imm_d[wr_ptr_q] = in_imm_c;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_c) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q alone
  always_ff @(posedge clk) begin
    fld_q <= fld_d;
    imm_q <= imm_d;
  end

  // Head-entry outputs, forced to zero when nothing is valid
  always_comb begin
    out_type    = '0;
    out_opcode  = '0;
    src1        = '0;
    src2        = '0;
    dest        = '0;
    cond        = '0;
    imm         = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_type    = fld_q[rd_ptr_q].typ;
      out_opcode  = fld_q[rd_ptr_q].opcode;
      src1        = fld_q[rd_ptr_q].src1;
      src2        = fld_q[rd_ptr_q].src2;
      dest        = fld_q[rd_ptr_q].dest;
      cond        = fld_q[rd_ptr_q].cond;
      imm         = imm_q[rd_ptr_q];
      out_illegal = fld_q[rd_ptr_q].illegal;
    end
  end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage with a decoded-field scoreboard.
module tb_inst_decode_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ZXLEN  = 40;
  localparam int unsigned ZDEPTH = 3;
  localparam logic [63:0] IMASK  = (64'd1 << XLEN) - 64'd1;

  typedef struct packed {
    logic [1:0]  typ;
    logic [3:0]  opc;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic [4:0]  c;
    logic        ill;
    logic [63:0] imm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [31:0]     inst = '0;
  logic            in_ready;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [1:0]      out_type;
  logic [3:0]      out_opcode;
  logic [4:0]      src1, src2, dest, cond;
  logic [XLEN-1:0] imm;
  logic            out_illegal;

  logic             z_in_valid = 1'b0;
  logic [31:0]      z_inst = '0;
  logic             z_in_ready;
  logic             z_out_valid;
  logic             z_out_ready = 1'b0;
  logic [1:0]       z_out_type;
  logic [3:0]       z_out_opcode;
  logic [4:0]       z_src1, z_src2, z_dest, z_cond;
  logic [ZXLEN-1:0] z_imm;
  logic             z_out_illegal;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  inst_decode_stage #(.XLEN(XLEN), .SIGN_EXT(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_opcode(out_opcode), .src1(src1), .src2(src2),
    .dest(dest), .cond(cond), .imm(imm), .out_illegal(out_illegal)
  );

  inst_decode_stage #(.XLEN(ZXLEN), .SIGN_EXT(0), .DEPTH(ZDEPTH)) dut_z (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .inst(z_inst), .in_ready(z_in_ready),
    .flush(1'b0), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_type(z_out_type), .out_opcode(z_out_opcode), .src1(z_src1), .src2(z_src2),
    .dest(z_dest), .cond(z_cond), .imm(z_imm), .out_illegal(z_out_illegal)
  );

  function automatic exp_t model(input logic [31:0] i);
    exp_t        e;
    logic [63:0] x;
    e = '0;
    x = {48'h0, i[31:16]};
    if (i[31]) x[63:16] = '1;
    case (i[1:0])
      2'b01: begin e.typ = 2'b01; e.opc = i[5:2]; e.s1 = i[10:6]; e.s2 = i[15:11]; e.d = i[20:16]; end
      2'b10: begin e.typ = 2'b10; e.opc = i[5:2]; e.s1 = i[10:6]; e.d = i[15:11]; e.imm = x; end
      2'b11: begin e.typ = 2'b11; e.opc = i[5:2]; e.s2 = i[10:6]; e.d = i[10:6]; e.c = i[15:11]; e.imm = x; end
      default: e.ill = 1'b1;
    endcase
    e.imm = e.imm & IMASK;
    return e;
  endfunction

  function automatic exp_t observe();
    return {out_type, out_opcode, src1, src2, dest, cond, out_illegal, 64'(imm)};
  endfunction

  // One clock: sample at negedge, update scoreboard, return after posedge
  task automatic cycle(output bit accepted);
    exp_t e, o;
    accepted = 1'b0;
    @(negedge clk);
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        o = observe();
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %h required no output", o);
        end else begin
          e = sb.pop_front();
          if (o !== e) begin
            errors++;
            $display("FAIL pop_fields: got %h required %h", o, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(inst));
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bit a;
    cycle(a);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (out_valid !== 1'b0 || observe() !== '0) begin
      errors++;
      $display("FAIL %s: got valid=%b fields=%h required valid=0 fields=0", name, out_valid, observe());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; inst = 32'h8000_5852;
    tick(); tick();
    check_idle("reset_outputs");
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_latency();
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h8000_5852;
    z_out_ready = 1'b0; z_in_valid = 1'b1; z_inst = 32'h8000_5852;
    #1;
    check_idle("no_bypass");
    tick();
    in_valid = 1'b0; z_in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || imm !== 32'hFFFF_8000 || src1 !== 5'd1 || dest !== 5'd11 ||
        out_type !== 2'b10 || out_opcode !== 4'd4) begin
      errors++;
      $display("FAIL latency_sext: got v=%b imm=%h s1=%0d d=%0d t=%b op=%0d required v=1 imm=ffff8000 s1=1 d=11 t=10 op=4",
               out_valid, imm, src1, dest, out_type, out_opcode);
    end
    checks++;
    if (z_out_valid !== 1'b1 || z_imm !== 40'h00_0000_8000) begin
      errors++;
      $display("FAIL latency_zext: got v=%b imm=%h required v=1 imm=0000008000", z_out_valid, z_imm);
    end
    out_ready = 1'b1; z_out_ready = 1'b1;
    tick();
    check_idle("latency_drained");
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      in_valid = 1'b1;
      inst = {$urandom()} & 32'hFFFF_FFFC | 32'h1;
      tick();
    end
    inst = 32'h1234_5679;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
    in_valid = 1'b0;
    tick();
    checks++;
    if (observe() !== sb[0]) begin errors++; $display("FAIL stall_hold: got %h required %h", observe(), sb[0]); end
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pushpop_ready: got %b required 1", in_ready); end
    tick();
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pushpop: got ready=%b valid=%b required ready=0 valid=1", in_ready, out_valid);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH) tick();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: got left=%0d valid=%b required left=0 valid=0", sb.size(), out_valid);
    end
  endtask

  task automatic test_stream();
    int n, sent, start_pops, budget;
    bit acc;
    n = 3 * int'(DEPTH); sent = 0; start_pops = pops; budget = 0;
    while ((sent < n || sb.size() != 0) && budget < 300) begin
      in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
      inst      = {$urandom()} | 32'h3;
      out_ready = ($urandom_range(0, 1) == 1);
      cycle(acc);
      if (acc) sent++;
      budget++;
    end
    in_valid = 1'b0;
    checks++;
    if (budget >= 300 || pops - start_pops != n) begin
      errors++;
      $display("FAIL stream_count: got popped=%0d cycles=%0d required popped=%0d within 300", pops - start_pops, budget, n);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; inst = 32'h0001_0842 + 32'(k << 6);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; inst = 32'h7FFF_FFFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_idle("flush_outputs");
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b required 1", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle("flush_no_emit");
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h0000_0000;
    tick();
    checks++;
    if (out_illegal !== 1'b1 || out_valid !== 1'b1 ||
        {out_type, out_opcode, src1, src2, dest, cond, imm} !== '0) begin
      errors++;
      $display("FAIL illegal_zero: got ill=%b v=%b fields=%h required ill=1 v=1 fields=0", out_illegal, out_valid, observe());
    end
    out_ready = 1'b1; inst = 32'hFFFF_FFFC;
    tick();
    in_valid = 1'b0;
    tick();
    check_idle("illegal_drained");
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; inst = 32'hC000_1003 + 32'(k << 11);
      tick();
    end
    rst = 1'b1; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b required 0", in_ready); end
    tick();
    check_idle("midrst_outputs");
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_hold: got %b required 0", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release: got %b required 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_stream();
    test_flush();
    test_illegal();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
